// File: rtl/full_adder_pkg.sv
// Shared definitions for the registered ripple adder.
//   MAX_WIDTH : widest supported operand width
//   ref_add   : behavioural {carry_out, sum} of a + b + c_in at a given width
package full_adder_pkg;

  localparam int unsigned MAX_WIDTH = 64;

  // Operands are zero-extended to MAX_WIDTH. Bits above position 'width' are masked off,
  // so the result is exactly {carry_out, sum} for that width.
  function automatic logic [MAX_WIDTH:0] ref_add(input logic [MAX_WIDTH-1:0] a,
                                                 input logic [MAX_WIDTH-1:0] b,
                                                 input logic                 c_in,
                                                 input int unsigned          width);
    logic [MAX_WIDTH:0] full;
    logic [MAX_WIDTH:0] mask;
    full = {1'b0, a} + {1'b0, b} + {{MAX_WIDTH{1'b0}}, c_in};
    // At width == MAX_WIDTH the shift clears everything and the subtraction gives all ones.
    mask = ({{MAX_WIDTH{1'b0}}, 1'b1} << (width + 1)) - 1'b1;
    return full & mask;
  endfunction

endpackage

// File: rtl/full_adder_reg_fa_cell.sv
// Combinational 1-bit full adder cell.
//   a_i, b_i    : operand bits
//   c_in_i      : carry in
//   sum_o       : a ^ b ^ c_in
//   carry_out_o : majority(a, b, c_in)
module fa_cell
  import full_adder_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  input  logic c_in_i,
  output logic sum_o,
  output logic carry_out_o
);

  assign sum_o       = a_i ^ b_i ^ c_in_i;
  assign carry_out_o = (a_i & b_i) | (a_i & c_in_i) | (b_i & c_in_i);

endmodule

// File: rtl/full_adder_reg.sv
// Registered ripple-carry adder: {carry_out, sum} = a + b + c_in, one clock of latency.
//   clk_i       : rising-edge clock
//   rst_n       : asynchronous active-low reset, clears all outputs
//   in_valid_i  : a_i, b_i, c_in_i are valid this cycle
//   a_i, b_i    : unsigned operands, WIDTH bits
//   c_in_i      : carry into bit 0
//   out_valid_o : outputs hold the result of a valid input captured on the last edge
//   sum_o       : registered sum, WIDTH bits
//   carry_out_o : registered carry out of the MSB
//   overflow_o  : registered signed overflow (carry into MSB ^ carry out of MSB)
module full_adder_reg
  import full_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_in_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_out_o,
  output logic             overflow_o
);

  // carry[i] is the carry into bit i; carry[WIDTH] leaves the MSB.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d;
  logic             carry_out_d;
  logic             overflow_d;

  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_out_q;
  logic             overflow_q;

  assign carry[0] = c_in_i;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fa_cell u_cell (
      .a_i         (a_i[i]),
      .b_i         (b_i[i]),
      .c_in_i      (carry[i]),
      .sum_o       (sum_d[i]),
      .carry_out_o (carry[i+1])
    );
  end

  always_comb begin
    carry_out_d = carry[WIDTH];
    overflow_d  = carry[WIDTH] ^ carry[WIDTH-1];
  end

  // Results only load on valid input; otherwise the last result is held.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      out_valid_q <= in_valid_i;
      if (in_valid_i) begin
        sum_q       <= sum_d;
        carry_out_q <= carry_out_d;
        overflow_q  <= overflow_d;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign sum_o       = sum_q;
  assign carry_out_o = carry_out_q;
  assign overflow_o  = overflow_q;

  // Cross-check the ripple chain against plain arithmetic.
  logic [MAX_WIDTH-1:0] a_ext;
  logic [MAX_WIDTH-1:0] b_ext;
  logic [MAX_WIDTH:0]   ref_sum;

  assign a_ext   = MAX_WIDTH'(a_i);
  assign b_ext   = MAX_WIDTH'(b_i);
  assign ref_sum = ref_add(a_ext, b_ext, c_in_i, WIDTH);

  a_ripple_matches_ref : assert property (@(posedge clk_i) disable iff (!rst_n)
    in_valid_i |-> (ref_sum == (MAX_WIDTH + 1)'({carry[WIDTH], sum_d})));

endmodule

// File: tb/tb_full_adder_reg.sv
module tb_full_adder_reg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // WIDTH = 1 instance
  logic       w1_in_valid = 1'b0;
  logic [0:0] w1_a = '0, w1_b = '0;
  logic       w1_c_in = 1'b0;
  logic       w1_out_valid;
  logic [0:0] w1_sum;
  logic       w1_carry_out, w1_overflow;

  // WIDTH = 8 instance
  logic       w8_in_valid = 1'b0;
  logic [7:0] w8_a = '0, w8_b = '0;
  logic       w8_c_in = 1'b0;
  logic       w8_out_valid;
  logic [7:0] w8_sum;
  logic       w8_carry_out, w8_overflow;

  // WIDTH = 16 instance
  logic        w16_in_valid = 1'b0;
  logic [15:0] w16_a = '0, w16_b = '0;
  logic        w16_c_in = 1'b0;
  logic        w16_out_valid;
  logic [15:0] w16_sum;
  logic        w16_carry_out, w16_overflow;

  full_adder_reg #(.WIDTH(1)) u_w1 (
    .clk_i       (clk),
    .rst_n       (rst_n),
    .in_valid_i  (w1_in_valid),
    .a_i         (w1_a),
    .b_i         (w1_b),
    .c_in_i      (w1_c_in),
    .out_valid_o (w1_out_valid),
    .sum_o       (w1_sum),
    .carry_out_o (w1_carry_out),
    .overflow_o  (w1_overflow)
  );

  full_adder_reg #(.WIDTH(8)) u_w8 (
    .clk_i       (clk),
    .rst_n       (rst_n),
    .in_valid_i  (w8_in_valid),
    .a_i         (w8_a),
    .b_i         (w8_b),
    .c_in_i      (w8_c_in),
    .out_valid_o (w8_out_valid),
    .sum_o       (w8_sum),
    .carry_out_o (w8_carry_out),
    .overflow_o  (w8_overflow)
  );

  full_adder_reg #(.WIDTH(16)) u_w16 (
    .clk_i       (clk),
    .rst_n       (rst_n),
    .in_valid_i  (w16_in_valid),
    .a_i         (w16_a),
    .b_i         (w16_b),
    .c_in_i      (w16_c_in),
    .out_valid_o (w16_out_valid),
    .sum_o       (w16_sum),
    .carry_out_o (w16_carry_out),
    .overflow_o  (w16_overflow)
  );

  // Reference model: signed overflow means the two's-complement sum leaves the w-bit range.
  function automatic longint to_signed(longint v, int w);
    return (v >= (64'sd1 <<< (w - 1))) ? v - (64'sd1 <<< w) : v;
  endfunction

  function automatic bit model_ovf(longint a, longint b, longint c, int w);
    longint s;
    s = to_signed(a, w) + to_signed(b, w) + c;
    return (s > (64'sd1 <<< (w - 1)) - 1) || (s < -(64'sd1 <<< (w - 1)));
  endfunction

  task automatic test_reset();
    #3;
    checks++;
    if ({w1_out_valid, w1_sum, w1_carry_out, w1_overflow} !== 4'b0 ||
        {w8_out_valid, w8_sum, w8_carry_out, w8_overflow} !== 11'b0 ||
        {w16_out_valid, w16_sum, w16_carry_out, w16_overflow} !== 19'b0) begin
      errors++;
      $display("FAIL reset_state: w1=%b w8=%h/%b w16=%h/%b, required all zero",
               {w1_out_valid, w1_sum, w1_carry_out, w1_overflow},
               w8_sum, {w8_out_valid, w8_carry_out, w8_overflow},
               w16_sum, {w16_out_valid, w16_carry_out, w16_overflow});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_w1_vectors();
    logic [2:0] vec [5] = '{3'b111, 3'b001, 3'b010, 3'b011, 3'b100};
    logic [1:0] exp [5] = '{2'b11, 2'b10, 2'b10, 2'b01, 2'b10}; // {sum, carry_out}
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      {w1_a, w1_b, w1_c_in} = vec[i];
      w1_in_valid = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({w1_out_valid, w1_sum, w1_carry_out} !== {1'b1, exp[i]}) begin
        errors++;
        $display("FAIL w1_vector[%0d]: got valid/sum/cout=%b required %b",
                 i, {w1_out_valid, w1_sum, w1_carry_out}, {1'b1, exp[i]});
      end
    end
  endtask

  task automatic test_w1_exhaustive();
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      int         pc;
      v  = 3'(i);
      pc = int'(v[0]) + int'(v[1]) + int'(v[2]);
      @(negedge clk);
      {w1_a, w1_b, w1_c_in} = v;
      w1_in_valid = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (w1_out_valid !== 1'b1 || {w1_carry_out, w1_sum} !== 2'(pc) ||
          w1_overflow !== (w1_carry_out ^ v[0] ? 1'b1 : 1'b0) ||
          w1_overflow !== model_ovf(longint'(v[2]), longint'(v[1]), longint'(v[0]), 1)) begin
        errors++;
        $display("FAIL w1_exhaustive[%b]: got valid=%b {cout,sum}=%b ovf=%b required 1 %b %b",
                 v, w1_out_valid, {w1_carry_out, w1_sum}, w1_overflow, 2'(pc),
                 model_ovf(longint'(v[2]), longint'(v[1]), longint'(v[0]), 1));
      end
    end
    @(negedge clk);
    w1_in_valid = 1'b0;
  endtask

  task automatic test_w8_boundaries();
    logic [16:0] vec [3] = '{{8'hFF, 8'h01, 1'b0}, {8'h7F, 8'h00, 1'b1}, {8'hFF, 8'hFF, 1'b1}};
    logic [9:0]  exp [3] = '{{8'h00, 1'b1, 1'b0}, {8'h80, 1'b0, 1'b1}, {8'hFF, 1'b1, 1'b0}};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      {w8_a, w8_b, w8_c_in} = vec[i];
      w8_in_valid = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (w8_out_valid !== 1'b1 || {w8_sum, w8_carry_out, w8_overflow} !== exp[i]) begin
        errors++;
        $display("FAIL w8_boundary[%0d]: got valid=%b sum=%h cout=%b ovf=%b required 1 %h %b %b",
                 i, w8_out_valid, w8_sum, w8_carry_out, w8_overflow,
                 exp[i][9:2], exp[i][1], exp[i][0]);
      end
    end
  endtask

  task automatic test_valid_gating();
    @(negedge clk);
    w8_a = 8'h10; w8_b = 8'h20; w8_c_in = 1'b0; w8_in_valid = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (w8_out_valid !== 1'b1 || w8_sum !== 8'h30 || w8_carry_out !== 1'b0) begin
      errors++;
      $display("FAIL gating_load: got valid=%b sum=%h cout=%b required 1 30 0",
               w8_out_valid, w8_sum, w8_carry_out);
    end
    @(negedge clk);
    w8_a = 8'hAA; w8_in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (w8_out_valid !== 1'b0 || w8_sum !== 8'h30 || w8_carry_out !== 1'b0 ||
        w8_overflow !== 1'b0) begin
      errors++;
      $display("FAIL gating_hold: got valid=%b sum=%h cout=%b ovf=%b required 0 30 0 0",
               w8_out_valid, w8_sum, w8_carry_out, w8_overflow);
    end
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    w8_a = 8'h05; w8_b = 8'h03; w8_c_in = 1'b0; w8_in_valid = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (w8_out_valid !== 1'b1 || w8_sum !== 8'h08) begin
      errors++;
      $display("FAIL mid_reset_pre: got valid=%b sum=%h required 1 08", w8_out_valid, w8_sum);
    end
    // A second valid input is pending when reset lands between edges.
    @(negedge clk);
    w8_a = 8'h05; w8_b = 8'h03; w8_in_valid = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({w8_out_valid, w8_sum, w8_carry_out, w8_overflow} !== 11'b0) begin
      errors++;
      $display("FAIL mid_reset_async: got valid=%b sum=%h cout=%b ovf=%b required all 0",
               w8_out_valid, w8_sum, w8_carry_out, w8_overflow);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({w8_out_valid, w8_sum, w8_carry_out, w8_overflow} !== 11'b0) begin
      errors++;
      $display("FAIL mid_reset_hold: got valid=%b sum=%h required 0 00", w8_out_valid, w8_sum);
    end
    @(negedge clk);
    w8_in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({w8_out_valid, w8_sum, w8_carry_out, w8_overflow} !== 11'b0) begin
      errors++;
      $display("FAIL mid_reset_release: got valid=%b sum=%h required 0 00",
               w8_out_valid, w8_sum);
    end
  endtask

  task automatic test_random_w16();
    bit          have_result = 1'b0;
    logic [15:0] exp_sum = '0;
    bit          exp_cout = 1'b0;
    bit          exp_ovf = 1'b0;
    int          local_err = 0;
    for (int i = 0; i < 10000; i++) begin
      logic [15:0] ra, rb;
      logic        rc, rv;
      int unsigned total;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      rv = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      w16_a = ra; w16_b = rb; w16_c_in = rc; w16_in_valid = rv;
      @(posedge clk);
      #1;
      if (rv) begin
        total       = int'(ra) + int'(rb) + int'(rc);
        exp_sum     = 16'(total % 65536);
        exp_cout    = (total >= 65536);
        exp_ovf     = model_ovf(longint'(ra), longint'(rb), longint'(rc), 16);
        have_result = 1'b1;
      end
      checks++;
      if (w16_out_valid !== rv || (have_result &&
          (w16_sum !== exp_sum || w16_carry_out !== exp_cout || w16_overflow !== exp_ovf))) begin
        errors++;
        if (local_err < 10)
          $display("FAIL random_w16[%0d]: got valid=%b sum=%h cout=%b ovf=%b required %b %h %b %b",
                   i, w16_out_valid, w16_sum, w16_carry_out, w16_overflow,
                   rv, exp_sum, exp_cout, exp_ovf);
        local_err++;
      end
    end
    @(negedge clk);
    w16_in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_w1_vectors();
    test_w1_exhaustive();
    test_w8_boundaries();
    test_valid_gating();
    test_reset_mid_op();
    test_random_w16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/full_adder_reg.md
Name: full_adder_reg

Overview:
- Registered, parameterizable-width binary adder: computes a + b + c_in and presents sum and carry_out one clock later.
- Datapath is a ripple chain of 1-bit full-adder cells, with a single output register stage and a valid qualifier.
- Used as the arithmetic leaf in datapaths that need a clean, registered add with explicit carry-in and carry-out.
- At WIDTH=1 it is exactly a registered 1-bit full adder.

Parameters:
- WIDTH, 1, operand and sum width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  a, b, c_in are valid this cycle
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- c_in  input  1  carry into bit 0
- out_valid  output  1  sum/carry_out/overflow hold the result of a valid input
- sum  output  WIDTH  registered (a + b + c_in) mod 2^WIDTH
- carry_out  output  1  registered carry out of the MSB
- overflow  output  1  registered signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset:
  - rst_n low clears out_valid, sum, carry_out and overflow to 0 immediately, without waiting for clk.
  - Outputs stay 0 while rst_n is low.
  - Reset asserted mid-operation discards any pending result; no result is emitted for inputs captured before reset.
- Datapath:
  - Purely combinational ripple through WIDTH 1-bit cells.
  - Cell i: s_i = a_i ^ b_i ^ c_i; c_{i+1} = (a_i & b_i) | (a_i & c_i) | (b_i & c_i); c_0 = c_in.
  - carry_out = c_WIDTH.
  - overflow = c_WIDTH ^ c_{WIDTH-1}. At WIDTH=1 this is c_out ^ c_in.
- Latency: exactly 1 clock.
  - Inputs sampled at rising edge N appear on the outputs after edge N, with out_valid=1.
- Valid handling:
  - out_valid <= in_valid on every edge.
  - When in_valid=0, sum/carry_out/overflow hold their previous values; they are not updated and not cleared.
  - Back-to-back valid inputs produce back-to-back results, one per cycle.
  - No backpressure: the block never stalls.
- Arithmetic:
  - Unsigned interpretation for sum/carry_out.
  - {carry_out, sum} == a + b + c_in exactly; max value 2^(WIDTH+1) - 1.
- X-handling: none required; inputs are assumed 0/1 when in_valid=1.

Decomposition:
- Shared package full_adder_pkg holds:
  - localparam MAX_WIDTH = 64
  - a function ref_add(a, b, c_in) returning {carry_out, sum}, for use by both RTL assertions and the bench scoreboard.
- One sub-module, fa_cell:
  - Combinational 1-bit full adder; ports a, b, c_in, sum, carry_out.
  - Instantiated WIDTH times in a generate loop.
- Top module holds the output register and the overflow/valid logic.

Test Plan:
- WIDTH=1, in_valid=1, apply five vectors one per cycle:
  - (1,1,1) -> sum=1, carry_out=1
  - (0,0,1) -> 1,0
  - (0,1,0) -> 1,0
  - (0,1,1) -> 0,1
  - (1,0,0) -> 1,0
  - Each result appears one cycle after its vector, with out_valid=1.
- WIDTH=1 exhaustive: all 8 combinations of a/b/c_in -> {carry_out,sum} equals popcount(a,b,c_in) each cycle.
- WIDTH=8 boundaries:
  - a=0xFF, b=0x01, c_in=0 -> sum=0x00, carry_out=1, overflow=0
  - a=0x7F, b=0x00, c_in=1 -> sum=0x80, carry_out=0, overflow=1
  - a=0xFF, b=0xFF, c_in=1 -> sum=0xFF, carry_out=1, overflow=0
- Valid gating, WIDTH=8:
  - Valid 0x10+0x20+0 -> sum=0x30.
  - Next cycle in_valid=0 with a=0xAA -> out_valid=0, sum holds 0x30.
- Reset mid-operation:
  - Drive valid 0x05+0x03.
  - Assert rst_n=0 between clock edges -> outputs go to 0 immediately with no edge; out_valid stays 0 on the first edge after release unless in_valid=1.
- Random: 10k random WIDTH=16 vectors with random in_valid -> outputs match ref_add at 1-cycle latency.
